sum_accumulator: RTL and testbench



---
 rtl/sum_acc_pkg.sv | 16 +
 rtl/sum_acc_beat_counter.sv | 31 +++
 rtl/sum_accumulator.sv | 146 ++++++++++++++
 tb/tb_sum_accumulator.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_acc_pkg.sv
// Shared types and constants for the sum_accumulator block.
// Holds the run-control FSM state encoding and the addend width
// produced by the upstream two_bit_adder ({cout, sum}, range 0..6).
package sum_acc_pkg;

    // Run-control states: waiting for start, collecting beats, holding result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // {cout, sum} from the two-bit adder.
    localparam int ADDEND_W = 3;

endpackage

// File: rtl/sum_acc_beat_counter.sv
// Beat counter for one accumulation run: clears on run start, increments per
// accepted beat, and flags the beat that completes the run.
// Ports: clk/rst (async active-high), clr, inc, count (CNT_W), last (count==N_SAMPLES-1).
module sum_acc_beat_counter
    import sum_acc_pkg::*;
#(
    parameter  int N_SAMPLES = 16,
    localparam int CNT_W     = $clog2(N_SAMPLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    // True while the next accepted beat is the final one of the run.
    assign last = (count == CNT_W'(N_SAMPLES - 1));

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates N_SAMPLES {cout,sum} addends from a two_bit_adder into an ACC_W
// register and offers the total over a valid/ready result handshake.
// Ports: clk, rst (async active-high), start, sum/cout/in_valid/in_ready beat
// input, result/res_valid/res_ready result output, busy, count, overflow status.
// Build option: define SUM_ACC_SATURATE_EN to clamp acc at all-ones on carry-out
// instead of wrapping; port list is the same in both builds.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter  int ACC_W     = 8,
    parameter  int N_SAMPLES = 16,
    localparam int CNT_W     = $clog2(N_SAMPLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       sum,
    input  logic             cout,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    state_t             state;
    state_t             state_nxt;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_nxt;
    logic [ACC_W-1:0]   addend;
    logic [ACC_W:0]     acc_sum;
    logic               carry;
    logic               accept;
    logic               run_start;
    logic               last_beat;

    // A new run only begins from IDLE; start elsewhere is ignored.
    assign run_start = (state == IDLE) && start;
    assign accept    = (state == ACC) && in_valid;

    // ------------------------------------------------------------------
    // Beat counter
    // ------------------------------------------------------------------
    sum_acc_beat_counter #(
        .N_SAMPLES (N_SAMPLES)
    ) u_beat_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (run_start),
        .inc   (accept),
        .count (count),
        .last  (last_beat)
    );

    // ------------------------------------------------------------------
    // Adder and optional saturation
    // ------------------------------------------------------------------
    assign addend  = ACC_W'({cout, sum});
    // One extra bit captures the carry-out of acc's MSB.
    assign acc_sum = {1'b0, acc} + {1'b0, addend};
    assign carry   = acc_sum[ACC_W];

`ifdef SUM_ACC_SATURATE_EN
    // Once clamped, every further non-zero addend carries again, so acc
    // stays at all-ones for the rest of the run.
    assign acc_nxt = carry ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
`else
    assign acc_nxt = acc_sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            overflow <= 1'b0;
        end else if (run_start) begin
            acc      <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            acc      <= acc_nxt;
            overflow <= overflow | carry;
        end
    end

    // ------------------------------------------------------------------
    // Run-control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ACC;
                end
            end
            ACC: begin
                if (accept && last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // start seen on the handshake cycle does not re-arm a run.
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Status outputs decode the registered state only, so neither in_valid
    // nor res_ready reaches an output combinationally.
    always_comb begin
        in_ready  = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ACC: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                res_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
            end
        endcase
    end

    assign result = acc;

endmodule

// File: tb/tb_sum_accumulator.sv
module tb_sum_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Default-parameter instance (ACC_W=8, N_SAMPLES=16)
    logic       start, in_valid, res_ready, cout;
    logic [1:0] sum;
    logic       in_ready, res_valid, busy, overflow;
    logic [7:0] result;
    logic [4:0] count;

    sum_accumulator dut (
        .clk(clk), .rst(rst), .start(start), .sum(sum), .cout(cout),
        .in_valid(in_valid), .in_ready(in_ready), .result(result),
        .res_valid(res_valid), .res_ready(res_ready), .busy(busy),
        .count(count), .overflow(overflow)
    );

    // Small instance (ACC_W=4, N_SAMPLES=4) for wrap/saturation corners
    logic       s_start, s_in_valid, s_res_ready, s_cout;
    logic [1:0] s_sum;
    logic       s_in_ready, s_res_valid, s_busy, s_overflow;
    logic [3:0] s_result;
    logic [2:0] s_count;

    sum_accumulator #(.ACC_W(4), .N_SAMPLES(4)) dut_small (
        .clk(clk), .rst(rst), .start(s_start), .sum(s_sum), .cout(s_cout),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .result(s_result),
        .res_valid(s_res_valid), .res_ready(s_res_ready), .busy(s_busy),
        .count(s_count), .overflow(s_overflow)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: run total as a plain integer, beats accepted so far.
    int model_total;
    int acc_cnt;

    typedef struct {
        logic [3:0][2:0] v;
        int              exp_wrap;
        int              exp_sat;
        int              exp_ovf;
    } small_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [2:0] two_bit_adder(input logic [1:0] a, input logic [1:0] b);
        return 3'({1'b0, a} + {1'b0, b});
    endfunction

    task automatic start_run();
        model_total = 0;
        acc_cnt     = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one beat until it is accepted; optional random bubbles.
    task automatic send_beat(input logic [2:0] v, input bit bubbles);
        bit done = 1'b0;
        for (int g = 0; g < 200 && !done; g++) begin
            @(negedge clk);
            if (bubbles) check("bubble_count", 32'(count), 32'(acc_cnt));
            {cout, sum} = v;
            in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            done = in_valid && in_ready;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout actual=not_accepted expected=accepted");
        end else begin
            acc_cnt++;
            model_total += int'(v);
        end
    endtask

    // Called at the negedge where the final beat awaits its accepting edge.
    task automatic finish_run(input string name);
        check({name, "_no_early_valid"}, 32'(res_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check({name, "_res_valid"}, 32'(res_valid), 32'd1);
        check({name, "_result"}, 32'(result), 32'(model_total % 256));
        check({name, "_overflow"}, 32'(overflow), 32'(model_total >= 256));
        check({name, "_count"}, 32'(count), 32'(acc_cnt));
    endtask

    task automatic drain(input string name);
        @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({name, "_drain_idle"}, 32'(res_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        small_vec_t tbl[6];
        int exp_r;

        tbl[0] = '{v: {3'd6, 3'd6, 3'd6, 3'd6}, exp_wrap: 8,  exp_sat: 15, exp_ovf: 1};
        tbl[1] = '{v: {3'd4, 3'd3, 3'd2, 3'd1}, exp_wrap: 10, exp_sat: 10, exp_ovf: 0};
        tbl[2] = '{v: {3'd0, 3'd0, 3'd0, 3'd0}, exp_wrap: 0,  exp_sat: 0,  exp_ovf: 0};
        tbl[3] = '{v: {3'd0, 3'd3, 3'd6, 3'd6}, exp_wrap: 15, exp_sat: 15, exp_ovf: 0};
        tbl[4] = '{v: {3'd0, 3'd4, 3'd6, 3'd6}, exp_wrap: 0,  exp_sat: 15, exp_ovf: 1};
        tbl[5] = '{v: {3'd0, 3'd6, 3'd6, 3'd5}, exp_wrap: 1,  exp_sat: 15, exp_ovf: 1};

        rst = 1'b1;
        start = 1'b0; in_valid = 1'b0; res_ready = 1'b0; cout = 1'b0; sum = 2'd0;
        s_start = 1'b0; s_in_valid = 1'b0; s_res_ready = 1'b0; s_cout = 1'b0; s_sum = 2'd0;
        model_total = 0;
        acc_cnt = 0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;

        // Async reset mid-run after 5 accepted beats
        start_run();
        check("acc_in_ready", 32'(in_ready), 32'd1);
        check("acc_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) send_beat(3'd3, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        check("pre_rst_count", 32'(count), 32'd5);
        check("pre_rst_result", 32'(result), 32'd15);
        rst = 1'b1;
        #1;
        check("async_rst_in_ready", 32'(in_ready), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_result", 32'(result), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        // 16 beats of value 6
        start_run();
        for (int i = 0; i < 16; i++) send_beat(3'd6, 1'b0);
        finish_run("sixes");
        check("sixes_result_96", 32'(result), 32'd96);

        // Backpressure in DONE with start and in_valid pulsing
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_res_valid", 32'(res_valid), 32'd1);
            check("bp_result", 32'(result), 32'd96);
            check("bp_count", 32'(count), 32'd16);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            start = ~start;
            in_valid = 1'b1;
        end
        // Handshake with a coincident start: start must be ignored.
        @(negedge clk);
        in_valid = 1'b0;
        res_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        start = 1'b0;
        check("hs_res_valid", 32'(res_valid), 32'd0);
        check("hs_busy", 32'(busy), 32'd0);
        check("hs_count_hold", 32'(count), 32'd16);
        @(negedge clk);
        check("hs_start_ignored", 32'(busy), 32'd0);

        // Bubbles with value 1
        start_run();
        for (int i = 0; i < 16; i++) send_beat(3'd1, 1'b1);
        finish_run("bubbles");
        drain("bubbles");

        // Live two-bit adder sweep; start pulsed mid-run must be ignored
        start_run();
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                start = (a == 2 && b == 0);
                send_beat(two_bit_adder(2'(a), 2'(b)), 1'b0);
            end
        end
        start = 1'b0;
        finish_run("adder");
        check("adder_result_48", 32'(result), 32'd48);
        drain("adder");

        // Randomized runs
        for (int r = 0; r < 4; r++) begin
            bit bub;
            bub = 1'($urandom_range(0, 1));
            start_run();
            for (int i = 0; i < 16; i++) send_beat(3'($urandom_range(0, 6)), bub);
            finish_run("random");
            drain("random");
        end

        // Small instance: wrap / saturation table
        for (int r = 0; r < 6; r++) begin
`ifdef SUM_ACC_SATURATE_EN
            exp_r = tbl[r].exp_sat;
`else
            exp_r = tbl[r].exp_wrap;
`endif
            @(negedge clk);
            s_start = 1'b1;
            @(negedge clk);
            s_start = 1'b0;
            for (int k = 0; k < 4; k++) begin
                check("small_in_ready", 32'(s_in_ready), 32'd1);
                {s_cout, s_sum} = tbl[r].v[k];
                s_in_valid = 1'b1;
                @(negedge clk);
            end
            s_in_valid = 1'b0;
            check("small_res_valid", 32'(s_res_valid), 32'd1);
            check("small_result", 32'(s_result), 32'(exp_r));
            check("small_overflow", 32'(s_overflow), 32'(tbl[r].exp_ovf));
            check("small_count", 32'(s_count), 32'd4);
            s_res_ready = 1'b1;
            @(negedge clk);
            s_res_ready = 1'b0;
            check("small_idle", 32'(s_busy), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
